// File: rtl/sub_pipe.sv
// sub_pipe: two-stage pipelined fixed-point subtractor, valueOne - valueTwo,
// for signed two's-complement Q(wholeWidth.fractionWidth) operands.
//
// Stage 1 registers the full W+1-bit difference. A single subtract over the
// whole word lets the fraction borrow carry into the whole part.
// Stage 2 registers the clamped or wrapped W-bit result and the overflow flag.
// Ready propagates combinationally from out_ready back to in_ready, so the
// pipe holds two pairs at most and moves one result per cycle when unstalled.
//
// Ports:
//   clock       rising-edge clock
//   reset_n     synchronous active-low reset; clears all state
//   in_valid    operand pair valid
//   in_ready    block can accept operands this cycle
//   valueOne    minuend, W bits signed
//   valueTwo    subtrahend, W bits signed
//   out_valid   difference valid
//   out_ready   downstream accepts difference
//   difference  result, W bits signed
//   overflow    result exceeded representable range; qualified by out_valid
module sub_pipe #(
   parameter int wholeWidth    = 4,
   parameter int fractionWidth = 4,
   parameter bit SATURATE      = 1'b1
) (
   input  logic                                  clock,
   input  logic                                  reset_n,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [wholeWidth+fractionWidth-1:0]   valueOne,
   input  logic [wholeWidth+fractionWidth-1:0]   valueTwo,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [wholeWidth+fractionWidth-1:0]   difference,
   output logic                                  overflow
);

   localparam int W = wholeWidth + fractionWidth;

   logic           s1_valid;
   logic [W:0]     s1_diff;
   logic           s2_valid;
   logic [W-1:0]   s2_diff;
   logic           s2_ovf;

   logic           s1_advance;
   logic           s2_advance;
   logic [W:0]     diff_full;
   logic           range_err;
   logic [W-1:0]   diff_sat;

   assign s2_advance = !s2_valid || out_ready;
   assign s1_advance = !s1_valid || s2_advance;
   assign in_ready   = s1_advance;

   // Sign-extend both operands so the W+1-bit result never wraps.
   assign diff_full = {valueOne[W-1], valueOne} - {valueTwo[W-1], valueTwo};

   // The top two bits disagree exactly when the result does not fit in W bits.
   assign range_err = s1_diff[W] ^ s1_diff[W-1];

   always_comb begin
      diff_sat = s1_diff[W-1:0];
      if (SATURATE && range_err) begin
         if (s1_diff[W])
            diff_sat = {1'b1, {(W-1){1'b0}}};
         else
            diff_sat = {1'b0, {(W-1){1'b1}}};
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_diff  <= '0;
         s2_valid <= 1'b0;
         s2_diff  <= '0;
         s2_ovf   <= 1'b0;
      end else begin
         if (s1_advance) begin
            s1_valid <= in_valid;
            if (in_valid)
               s1_diff <= diff_full;
         end
         if (s2_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_diff <= diff_sat;
               s2_ovf  <= range_err;
            end
         end
      end
   end

   assign out_valid  = s2_valid;
   assign difference = s2_diff;
   assign overflow   = s2_ovf;

endmodule
